// File: rtl/wb_pkg.sv
// Shared encodings for the register-file writeback arbiter: execute source
// selects, arbiter state and the default starvation bound.
package wb_pkg;

  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_PC4 = 2'b01;
  localparam logic [1:0] WB_SEL_LUI = 2'b10;

  localparam int WB_STARVE_MAX = 4;

  typedef enum logic {
    WB_NORMAL = 1'b0,
    WB_HOLD   = 1'b1
  } wb_state_t;

endpackage

// File: rtl/wb_src_mux.sv
// Execute writeback source select (ALU / PC+4 / LUI immediate).
// Purely combinational, zero latency, no flow control.
module wb_src_mux
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      ex_sel,
  input  logic [XLEN-1:0] ex_alu,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  output logic [XLEN-1:0] data
);

  // Reserved encoding 11 falls through to the ALU result.
  always_comb begin
    data = ex_alu;
    case (ex_sel)
      WB_SEL_PC4: data = ex_pc + XLEN'(4);
      WB_SEL_LUI: data = ex_imm;
      default:    data = ex_alu;
    endcase
  end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write port arbiter: loads win, execute forced after STARVE_MAX denials.
// One-cycle grant-to-write latency; a load losing to a forced execute parks in a one-entry hold.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = WB_STARVE_MAX
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [4:0]      ex_rd,
  input  logic [1:0]      ex_sel,
  input  logic [XLEN-1:0] ex_alu,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [4:0]      ld_rd,
  input  logic [XLEN-1:0] ld_data,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  wb_state_t       state, state_nxt;
  logic [3:0]      starve_cnt;
  logic [4:0]      hold_rd;
  logic [XLEN-1:0] hold_data;
  logic [XLEN-1:0] ex_data;

  logic            force_ex;
  logic            grant_ex, grant_ld, grant_hold, hold_cap;
  logic            wr_go;
  logic [4:0]      wr_rd;
  logic [XLEN-1:0] wr_data;

  wb_src_mux #(.XLEN(XLEN)) u_src_mux (
    .ex_sel (ex_sel),
    .ex_alu (ex_alu),
    .ex_pc  (ex_pc),
    .ex_imm (ex_imm),
    .data   (ex_data)
  );

  assign force_ex = ex_valid && (starve_cnt == STARVE_LIM);

  always_comb begin
    state_nxt  = state;
    grant_ex   = 1'b0;
    grant_ld   = 1'b0;
    grant_hold = 1'b0;
    hold_cap   = 1'b0;
    ld_ready   = (state == WB_NORMAL);
    case (state)
      WB_NORMAL: begin
        if (force_ex) begin
          grant_ex = 1'b1;
          if (ld_valid) begin
            hold_cap  = 1'b1;
            state_nxt = WB_HOLD;
          end
        end else if (ld_valid) begin
          grant_ld = 1'b1;
        end else if (ex_valid) begin
          grant_ex = 1'b1;
        end
      end
      WB_HOLD: begin
        if (force_ex) begin
          grant_ex = 1'b1;
        end else begin
          grant_hold = 1'b1;
          state_nxt  = WB_NORMAL;
        end
      end
      default: state_nxt = WB_NORMAL;
    endcase
    ex_ready = grant_ex;
  end

  always_comb begin
    wr_go   = grant_ex || grant_ld || grant_hold;
    wr_rd   = ex_rd;
    wr_data = ex_data;
    if (grant_ld) begin
      wr_rd   = ld_rd;
      wr_data = ld_data;
    end else if (grant_hold) begin
      wr_rd   = hold_rd;
      wr_data = hold_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= WB_NORMAL;
      starve_cnt <= '0;
      hold_rd    <= '0;
      hold_data  <= '0;
    end else begin
      state <= state_nxt;
      if (!ex_valid || grant_ex) begin
        starve_cnt <= '0;
      end else if (starve_cnt != STARVE_LIM) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
      if (hold_cap) begin
        hold_rd   <= ld_rd;
        hold_data <= ld_data;
      end
    end
  end

  // Writes to x0 still consume the grant slot but never assert the enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= wr_go && (wr_rd != 5'd0);
      if (wr_go) begin
        rf_waddr <= wr_rd;
        rf_wdata <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with a write scoreboard and immediate assertions.
module tb_wb_arbiter;

  localparam int SRC_NONE = 0;
  localparam int SRC_EX   = 1;
  localparam int SRC_LD   = 2;
  localparam int SRC_HOLD = 3;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [4:0]  ex_rd = '0;
  logic [1:0]  ex_sel = '0;
  logic [31:0] ex_alu = '0;
  logic [31:0] ex_pc = '0;
  logic [31:0] ex_imm = '0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [4:0]  ld_rd = '0;
  logic [31:0] ld_data = '0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int vectors = 0;
  int miscompares = 0;

  wr_t         sb[$];
  logic [4:0]  last_addr = '0;
  logic [31:0] last_data = '0;
  logic [4:0]  m_hold_rd = '0;
  logic [31:0] m_hold_data = '0;

  always #5 clk = ~clk;

  wb_arbiter #(.XLEN(32), .STARVE_MAX(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .ex_valid (ex_valid),
    .ex_ready (ex_ready),
    .ex_rd    (ex_rd),
    .ex_sel   (ex_sel),
    .ex_alu   (ex_alu),
    .ex_pc    (ex_pc),
    .ex_imm   (ex_imm),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .ld_rd    (ld_rd),
    .ld_data  (ld_data),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata)
  );

  function automatic logic [31:0] ex_model(input logic [1:0] s, input logic [31:0] a,
                                           input logic [31:0] p, input logic [31:0] i);
    case (s)
      2'b01:   return p + 32'd4;
      2'b10:   return i;
      default: return a;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One arbitration cycle: inputs are already driven; check handshakes, predict the write,
  // then check the registered write port one edge later.
  task automatic step(input string tag, input logic exr, input logic ldr, input int src);
    wr_t e;
    wr_t got;
    #1;
    chk({tag, ".ex_ready"}, 32'(ex_ready), 32'(exr));
    chk({tag, ".ld_ready"}, 32'(ld_ready), 32'(ldr));
    e = '{we: 1'b0, addr: last_addr, data: last_data};
    case (src)
      SRC_EX: begin
        e.addr = ex_rd;
        e.data = ex_model(ex_sel, ex_alu, ex_pc, ex_imm);
        if (ld_valid && ldr) begin
          m_hold_rd   = ld_rd;
          m_hold_data = ld_data;
        end
      end
      SRC_LD:   begin e.addr = ld_rd;     e.data = ld_data;     end
      SRC_HOLD: begin e.addr = m_hold_rd; e.data = m_hold_data; end
      default:  ;
    endcase
    if (src != SRC_NONE) e.we = (e.addr != 5'd0);
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk({tag, ".rf_we"},    32'(rf_we),    32'(got.we));
    chk({tag, ".rf_waddr"}, 32'(rf_waddr), 32'(got.addr));
    chk({tag, ".rf_wdata"}, rf_wdata,      got.data);
    last_addr = got.addr;
    last_data = got.data;
  endtask

  task automatic set_ex(input logic v, input logic [4:0] rd, input logic [1:0] sel,
                        input logic [31:0] alu, input logic [31:0] pc, input logic [31:0] imm);
    ex_valid = v; ex_rd = rd; ex_sel = sel; ex_alu = alu; ex_pc = pc; ex_imm = imm;
  endtask

  task automatic set_ld(input logic v, input logic [4:0] rd, input logic [31:0] d);
    ld_valid = v; ld_rd = rd; ld_data = d;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst.rf_we",    32'(rf_we),    32'd0);
    chk("rst.rf_waddr", 32'(rf_waddr), 32'd0);
    chk("rst.rf_wdata", rf_wdata,      32'd0);
    chk("rst.ld_ready", 32'(ld_ready), 32'd1);
    chk("rst.ex_ready", 32'(ex_ready), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Execute only, PC+4 wraps to zero
    set_ex(1'b1, 5'd5, 2'b01, 32'h0, 32'hFFFF_FFFC, 32'h0);
    step("exonly", 1'b1, 1'b1, SRC_EX);
    chk("exonly.wrap", rf_wdata, 32'h0000_0000);
    set_ex(1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0);
    step("idle0", 1'b0, 1'b1, SRC_NONE);

    // Simultaneous: load first, execute next free cycle
    set_ld(1'b1, 5'd3, 32'hDEAD_BEEF);
    set_ex(1'b1, 5'd4, 2'b10, 32'h0, 32'h0, 32'h1234_5000);
    step("simul.ld", 1'b0, 1'b1, SRC_LD);
    set_ld(1'b0, 5'd0, 32'h0);
    step("simul.ex", 1'b1, 1'b1, SRC_EX);
    set_ex(1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0);
    step("idle1", 1'b0, 1'b1, SRC_NONE);

    // Starvation: fresh load every cycle, execute forced on cycle 4
    set_ex(1'b1, 5'd7, 2'b00, 32'h0000_0077, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      set_ld(1'b1, 5'(8 + i), 32'h1000 + 32'(i));
      step("starve.ld", 1'b0, 1'b1, SRC_LD);
    end
    set_ld(1'b1, 5'd12, 32'h0000_1004);
    step("starve.force", 1'b1, 1'b1, SRC_EX);
    set_ex(1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0);
    set_ld(1'b1, 5'd13, 32'h0000_1005);
    step("starve.drain", 1'b0, 1'b0, SRC_HOLD);
    step("starve.next", 1'b0, 1'b1, SRC_LD);
    set_ld(1'b0, 5'd0, 32'h0);
    step("idle2", 1'b0, 1'b1, SRC_NONE);

    // rd = 0 write is accepted but suppressed
    set_ex(1'b1, 5'd0, 2'b00, 32'h0000_0055, 32'h0, 32'h0);
    step("rd0", 1'b1, 1'b1, SRC_EX);
    set_ex(1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0);
    step("idle3", 1'b0, 1'b1, SRC_NONE);

    // Reserved select behaves as ALU
    set_ex(1'b1, 5'd9, 2'b11, 32'hA5A5_A5A5, 32'h1111_1111, 32'h2222_2222);
    step("sel11", 1'b1, 1'b1, SRC_EX);
    chk("sel11.data", rf_wdata, 32'hA5A5_A5A5);
    set_ex(1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0);
    step("idle4", 1'b0, 1'b1, SRC_NONE);

    // Reset while hold is full: held load must never be written
    set_ex(1'b1, 5'd10, 2'b00, 32'h0000_00AA, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      set_ld(1'b1, 5'(16 + i), 32'h2000 + 32'(i));
      step("rsth.ld", 1'b0, 1'b1, SRC_LD);
    end
    set_ld(1'b1, 5'd21, 32'hBAD0_0BAD);
    step("rsth.force", 1'b1, 1'b1, SRC_EX);
    set_ex(1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0);
    set_ld(1'b0, 5'd0, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    chk("rsth.rf_we",    32'(rf_we),    32'd0);
    chk("rsth.rf_waddr", 32'(rf_waddr), 32'd0);
    chk("rsth.rf_wdata", rf_wdata,      32'd0);
    chk("rsth.ld_ready", 32'(ld_ready), 32'd1);
    @(posedge clk);
    #3;
    rst = 1'b0;
    last_addr = '0;
    last_data = '0;
    @(posedge clk); #1;
    step("rsth.after0", 1'b0, 1'b1, SRC_NONE);
    step("rsth.after1", 1'b0, 1'b1, SRC_NONE);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
